// File: rtl/mbist_bg_pkg.sv
// Shared codes, FSM state type and mask-scan helper for the MBIST background generator.
package mbist_bg_pkg;

  localparam int BG_SOLID     = 0;
  localparam int BG_CHECK     = 1;
  localparam int BG_PAIR      = 2;
  localparam int BG_ROWSTRIPE = 3;
  localparam int BG_PHYSCHK   = 4;
  localparam int BG_NUM       = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bg_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] code;
  } bg_sel_t;

  // Lowest set mask bit whose index is >= floor_idx; found=0 when none remains.
  function automatic bg_sel_t lowest_set_from(input logic [BG_NUM-1:0] mask,
                                              input logic [3:0]        floor_idx);
    bg_sel_t sel;
    sel = '0;
    for (int i = BG_NUM - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(floor_idx))) begin
        sel.found = 1'b1;
        sel.code  = 3'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/mbist_bg_gen_bg_pattern.sv
// Combinational background code + address -> raw (non-inverted) data word.
// Reserved and SOLID codes both yield an all-zero word.
module bg_pattern
  import mbist_bg_pkg::*;
#(
  parameter int WLENGTH  = 4,
  parameter int ADDR_W   = 8,
  parameter int COL_BITS = 2
) (
  input  logic [2:0]         i_code,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic [WLENGTH-1:0] o_word
);

  logic w_col0;
  logic w_row;
  logic w_unused_addr;

  assign w_col0        = i_addr[0];
  assign w_row         = i_addr[COL_BITS];
  assign w_unused_addr = ^i_addr;

  always_comb begin
    o_word = '0;
    for (int b = 0; b < WLENGTH; b++) begin
      case (i_code)
        3'(BG_CHECK):     o_word[b] = ((b % 2) == 0);
        3'(BG_PAIR):      o_word[b] = (((b / 2) % 2) == 0);
        3'(BG_ROWSTRIPE): o_word[b] = w_row;
        3'(BG_PHYSCHK):   o_word[b] = ((b % 2) == 0) ^ w_col0 ^ w_row;
        default:          o_word[b] = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mbist_bg_gen.sv
// MBIST background sequencer (IDLE->RUN->DONE) plus a 2-stage address-dependent
// data-word pipeline that follows the live bg_code/bg_inv registers.
module mbist_bg_gen
  import mbist_bg_pkg::*;
#(
  parameter int WLENGTH  = 4,
  parameter int ADDR_W   = 8,
  parameter int COL_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         bg_mask,
  input  logic               bg_next,
  output logic               bg_valid,
  output logic [2:0]         bg_code,
  output logic               bg_inv,
  output logic               done,
  output logic               bg_err,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               addr_valid,
  output logic [WLENGTH-1:0] data,
  output logic               data_valid
);

  bg_state_t         r_state;
  logic [BG_NUM-1:0] r_mask;
  logic              r_bg_valid;
  logic [2:0]        r_bg_code;
  logic              r_bg_inv;
  logic              r_done;
  logic              r_bg_err;

  bg_sel_t w_sel_start;
  bg_sel_t w_sel_next;

  assign w_sel_start = lowest_set_from(bg_mask[BG_NUM-1:0], 4'd0);
  assign w_sel_next  = lowest_set_from(r_mask, {1'b0, r_bg_code} + 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_mask     <= '0;
      r_bg_valid <= 1'b0;
      r_bg_code  <= '0;
      r_bg_inv   <= 1'b0;
      r_done     <= 1'b0;
      r_bg_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state    <= ST_IDLE;
        r_bg_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_mask   <= bg_mask[BG_NUM-1:0];
              r_bg_err <= |bg_mask[7:BG_NUM];
              if (w_sel_start.found) begin
                r_state    <= ST_RUN;
                r_bg_valid <= 1'b1;
                r_bg_code  <= w_sel_start.code;
                r_bg_inv   <= 1'b0;
              end else begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (bg_next) begin
              if (!r_bg_inv) begin
                r_bg_inv <= 1'b1;
              end else if (w_sel_next.found) begin
                r_bg_code <= w_sel_next.code;
                r_bg_inv  <= 1'b0;
              end else begin
                // Last polarity of last code: code/inv stay put for the datapath.
                r_state    <= ST_DONE;
                r_bg_valid <= 1'b0;
                r_done     <= 1'b1;
              end
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bg_valid = r_bg_valid;
  assign bg_code  = r_bg_code;
  assign bg_inv   = r_bg_inv;
  assign done     = r_done;
  assign bg_err   = r_bg_err;

  logic [WLENGTH-1:0] w_raw;
  logic               r_s1_vld;
  logic [WLENGTH-1:0] r_s1_word;
  logic               r_s1_inv;
  logic               r_s2_vld;
  logic [WLENGTH-1:0] r_s2_dat;

  bg_pattern #(
    .WLENGTH  (WLENGTH),
    .ADDR_W   (ADDR_W),
    .COL_BITS (COL_BITS)
  ) u_bg_pattern (
    .i_code (r_bg_code),
    .i_addr (addr),
    .o_word (w_raw)
  );

  // Stage 1 captures pattern and polarity together, so a bg_next in the
  // same cycle cannot split them across backgrounds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_word <= '0;
      r_s1_inv  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s2_dat  <= '0;
    end else begin
      r_s1_vld  <= addr_valid;
      r_s1_word <= w_raw;
      r_s1_inv  <= r_bg_inv;
      r_s2_vld  <= r_s1_vld;
      r_s2_dat  <= r_s1_word ^ {WLENGTH{r_s1_inv}};
    end
  end

  assign data       = r_s2_dat;
  assign data_valid = r_s2_vld;

endmodule
